exe_arbiter: RTL and testbench

EXE_ARBITER -- requirements
Module: exe_arbiter

---
 rtl/exe_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/exe_arbiter.sv | 144 ++++++++++++++
 tb/tb_exe_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execution-unit arbiter: FSM states, opcode width
// and the opcode values also decoded by the execution unit.
package exe_pkg;

    localparam int OPW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } exe_state_e;

    localparam logic [OPW-1:0] OP_ADD = 2'd0;
    localparam logic [OPW-1:0] OP_SUB = 2'd1;
    localparam logic [OPW-1:0] OP_SHL = 2'd2;
    localparam logic [OPW-1:0] OP_SHR = 2'd3;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester named by ptr. Output is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // Grant decode from request pattern and tie-break pointer
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/exe_arbiter.sv
// Shares one combinational execution unit between two requesters with a
// three-state IDLE/EXEC/RESP handshake and round-robin fairness.
module exe_arbiter #(
    parameter int N   = 8,
    parameter int OPW = exe_pkg::OPW
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic [OPW-1:0] exe_op,
    output logic [N-1:0]   exe_a,
    output logic [N-1:0]   exe_b,
    input  logic [N-1:0]   exe_result,
    input  logic           exe_error,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [N-1:0]   rsp0_result,
    output logic           rsp0_error,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [N-1:0]   rsp1_result,
    output logic           rsp1_error,
    output logic           busy,
    output logic [7:0]     err_cnt
);

    import exe_pkg::*;

    exe_state_e     state_r;
    logic           ptr_r;
    logic           id_r;
    logic [OPW-1:0] op_r;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [N-1:0]   res_r;
    logic           err_r;
    logic [7:0]     err_cnt_r;

    logic [1:0]     req_s;
    logic [1:0]     gnt_s;
    logic           xfer_s;
    logic           rsp_take_s;

    assign req_s = {req1_valid, req0_valid};

    rr_arb2 u_rr_arb2 (
        .req (req_s),
        .ptr (ptr_r),
        .gnt (gnt_s)
    );

    // Ready is offered only from IDLE; the response is taken by the owner only
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_take_s = 1'b0;
        if (state_r == IDLE) begin
            req0_ready = gnt_s[0];
            req1_ready = gnt_s[1];
        end else if (state_r == RESP) begin
            rsp_take_s = id_r ? rsp1_ready : rsp0_ready;
        end else begin
            rsp_take_s = 1'b0;
        end
    end

    assign xfer_s = req0_ready | req1_ready;

    // Operation state machine
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE:    state_r <= xfer_s ? EXEC : IDLE;
                EXEC:    state_r <= RESP;
                RESP:    state_r <= rsp_take_s ? IDLE : RESP;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Request latch; these registers drive the execution unit directly so its
    // inputs only move on a new grant
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            id_r <= 1'b0;
            op_r <= {OPW{1'b0}};
            a_r  <= {N{1'b0}};
            b_r  <= {N{1'b0}};
        end else if ((state_r == IDLE) && xfer_s) begin
            id_r <= gnt_s[1];
            op_r <= gnt_s[1] ? req1_op : req0_op;
            a_r  <= gnt_s[1] ? req1_a  : req0_a;
            b_r  <= gnt_s[1] ? req1_b  : req0_b;
        end
    end

    // Result capture and error accounting at the end of EXEC
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            res_r     <= {N{1'b0}};
            err_r     <= 1'b0;
            err_cnt_r <= 8'd0;
        end else if (state_r == EXEC) begin
            res_r <= exe_result;
            err_r <= exe_error;
            if (exe_error) begin
                err_cnt_r <= sat_inc8(err_cnt_r);
            end
        end
    end

    // Fairness pointer flips to the other requester once a response is taken
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ptr_r <= 1'b0;
        end else if (rsp_take_s) begin
            ptr_r <= ~id_r;
        end
    end

    assign exe_op      = op_r;
    assign exe_a       = a_r;
    assign exe_b       = b_r;
    assign rsp0_valid  = (state_r == RESP) && !id_r;
    assign rsp1_valid  = (state_r == RESP) && id_r;
    assign rsp0_result = res_r;
    assign rsp1_result = res_r;
    assign rsp0_error  = err_r;
    assign rsp1_error  = err_r;
    assign busy        = (state_r != IDLE);
    assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_exe_arbiter.sv
// Randomised and directed bench for exe_arbiter; a transaction-level model
// predicts grants, response timing, payloads and the error count.
module tb_exe_arbiter;

    localparam int N   = 8;
    localparam int OPW = 2;

    import exe_pkg::*;

    logic           PCLK = 1'b0;
    logic           PRESETn = 1'b0;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OPW-1:0] req0_op, req1_op, exe_op;
    logic [N-1:0]   req0_a, req0_b, req1_a, req1_b, exe_a, exe_b, exe_result;
    logic           exe_error;
    logic           rsp0_valid, rsp0_ready, rsp0_error, rsp1_valid, rsp1_ready, rsp1_error;
    logic [N-1:0]   rsp0_result, rsp1_result;
    logic           busy;
    logic [7:0]     err_cnt;

    always #5 PCLK = ~PCLK;

    exe_arbiter #(.N(N), .OPW(OPW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .exe_op(exe_op), .exe_a(exe_a), .exe_b(exe_b),
        .exe_result(exe_result), .exe_error(exe_error),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_error(rsp0_error),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_error(rsp1_error),
        .busy(busy), .err_cnt(err_cnt)
    );

    // Behavioural execution unit: {error, result}
    function automatic logic [N:0] exe_fn(input logic [OPW-1:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
        logic signed [N-1:0] sa;
        logic signed [N-1:0] sb;
        logic signed [N-1:0] r;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            OP_ADD: r = sa + sb;
            OP_SUB: r = sa - sb;
            OP_SHL: if (sb < 0) return {1'b1, {N{1'b0}}}; else r = sa <<< sb;
            OP_SHR: if (sb < 0) return {1'b1, {N{1'b0}}}; else r = sa >>> sb;
            default: r = '0;
        endcase
        return {1'b0, r};
    endfunction

    always_comb {exe_error, exe_result} = exe_fn(exe_op, exe_a, exe_b);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: one operation in flight, age counts cycles since grant
    bit           m_busy;
    int           m_age, m_id, m_pref, m_errcnt;
    logic [OPW-1:0] m_op;
    logic [N-1:0] m_a, m_b, m_res;
    bit           m_err;
    bit           acc_flag, done_flag;
    int           acc_id;
    logic [N-1:0] obs_res;
    logic         obs_err;

    task automatic idle_inputs();
        req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic set_req(input int id, input bit v, input int op, input int a, input int b);
        if (id == 0) begin
            req0_valid = v; req0_op = op[OPW-1:0]; req0_a = a[N-1:0]; req0_b = b[N-1:0];
        end else begin
            req1_valid = v; req1_op = op[OPW-1:0]; req1_a = a[N-1:0]; req1_b = b[N-1:0];
        end
    endtask

    // Called just after a rising edge with inputs driven; checks, then advances
    task automatic cycle();
        bit e_r0, e_r1;
        logic [N:0] r;
        #1;
        e_r0 = !m_busy && req0_valid && (!req1_valid || m_pref == 0);
        e_r1 = !m_busy && req1_valid && (!req0_valid || m_pref == 1);
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("busy", busy, m_busy);
        chk("rsp0_valid", rsp0_valid, m_busy && m_age >= 2 && m_id == 0);
        chk("rsp1_valid", rsp1_valid, m_busy && m_age >= 2 && m_id == 1);
        if (m_busy && m_age >= 2) begin
            obs_res = (m_id == 0) ? rsp0_result : rsp1_result;
            obs_err = (m_id == 0) ? rsp0_error : rsp1_error;
            chk("rsp_result", obs_res, m_res);
            chk("rsp_error", obs_err, m_err);
        end
        chk("exe_op", exe_op, m_op);
        chk("exe_a", exe_a, m_a);
        chk("exe_b", exe_b, m_b);
        chk("err_cnt", err_cnt, m_errcnt);
        acc_flag  = 0;
        done_flag = 0;
        @(posedge PCLK);
        if (!m_busy) begin
            if (e_r0 || e_r1) begin
                acc_flag = 1;
                acc_id   = e_r1 ? 1 : 0;
                m_busy   = 1;
                m_age    = 1;
                m_id     = acc_id;
                m_op     = e_r1 ? req1_op : req0_op;
                m_a      = e_r1 ? req1_a : req0_a;
                m_b      = e_r1 ? req1_b : req0_b;
                r        = exe_fn(m_op, m_a, m_b);
                m_res    = r[N-1:0];
                m_err    = r[N];
            end
        end else if (m_age == 1) begin
            m_age = 2;
            if (m_err && m_errcnt < 255) m_errcnt++;
        end else if ((m_id == 0 && rsp0_ready) || (m_id == 1 && rsp1_ready)) begin
            m_busy    = 0;
            m_pref    = 1 - m_id;
            done_flag = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        PRESETn = 0;
        idle_inputs();
        m_busy = 0; m_age = 0; m_id = 0; m_pref = 0; m_errcnt = 0;
        m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_err = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_exe_a", exe_a, 0);
        chk("rst_exe_b", exe_b, 0);
        chk("rst_exe_op", exe_op, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_rsp0_result", rsp0_result, 0);
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1;
    endtask

    task automatic run_op(input int id, input int op, input int a, input int b, input int hold,
                          input bit keep_other, output int acc_cycles, output int rsp_cycles);
        int w;
        set_req(id, 1, op, a, b);
        set_req(1 - id, 0, 0, 0, 0);
        rsp0_ready = 0;
        rsp1_ready = 0;
        acc_cycles = 0;
        do begin
            cycle();
            acc_cycles++;
        end while (!acc_flag && acc_cycles < 10);
        chk("accept_seen", acc_flag, 1);
        set_req(id, 0, 0, 0, 0);
        if (keep_other) set_req(1 - id, 1, OP_ADD, 1, 2);
        rsp_cycles = 0;
        w = 0;
        do begin
            rsp0_ready = (id == 0) && (w > hold);
            rsp1_ready = (id == 1) && (w > hold);
            cycle();
            w++;
            rsp_cycles++;
        end while (!done_flag && w < 30);
        chk("done_seen", done_flag, 1);
        rsp0_ready = 0;
        rsp1_ready = 0;
    endtask

    initial begin
        int acc_c, rsp_c, n;
        int order[$];

        idle_inputs();
        do_reset();
        repeat (3) cycle();

        // Single SHL 3<<2
        run_op(0, OP_SHL, 3, 2, 0, 0, acc_c, rsp_c);
        chk("shl_result", obs_res, 12);
        chk("shl_error", obs_err, 0);
        chk("shl_latency", rsp_c, 2);

        // Contention right after reset: 0, 1, 0
        do_reset();
        set_req(0, 1, OP_ADD, 1, 1);
        set_req(1, 1, OP_SUB, 5, 2);
        rsp0_ready = 1;
        rsp1_ready = 1;
        n = 0;
        while (order.size() < 3 && n < 20) begin
            cycle();
            if (acc_flag) order.push_back(acc_id);
            n++;
        end
        chk("rr_count", order.size(), 3);
        if (order.size() >= 3) begin
            chk("rr_first", order[0], 0);
            chk("rr_second", order[1], 1);
            chk("rr_third", order[2], 0);
        end
        idle_inputs();
        rsp0_ready = 1;
        rsp1_ready = 1;
        n = 0;
        while (m_busy && n < 10) begin cycle(); n++; end
        idle_inputs();

        // Negative shift errors and counter saturation
        do_reset();
        run_op(0, OP_SHL, 5, -1, 0, 0, acc_c, rsp_c);
        chk("neg_err", obs_err, 1);
        chk("neg_res", obs_res, 0);
        chk("err_cnt_one", err_cnt, 1);
        for (int i = 1; i < 300; i++) run_op(i % 2, OP_SHR, 9, -1, 0, 0, acc_c, rsp_c);
        chk("err_cnt_sat", err_cnt, 255);

        // Backpressure on rsp1 while req0 waits
        run_op(1, OP_ADD, 7, 9, 5, 1, acc_c, rsp_c);
        chk("bp_rsp_cycles", rsp_c, 7);
        chk("bp_result", obs_res, 16);
        run_op(0, OP_SUB, 4, 1, 0, 0, acc_c, rsp_c);
        chk("req0_after_rsp1", acc_c, 1);

        // Reset during EXEC discards the operation
        set_req(1, 1, OP_ADD, 3, 3);
        n = 0;
        do begin cycle(); n++; end while (!acc_flag && n < 10);
        chk("exec_accept", acc_flag, 1);
        do_reset();
        rsp0_ready = 1;
        rsp1_ready = 1;
        repeat (4) cycle();
        set_req(0, 1, OP_ADD, 2, 2);
        set_req(1, 1, OP_ADD, 6, 6);
        cycle();
        chk("post_rst_grant", acc_id, 0);
        chk("post_rst_accept", acc_flag, 1);
        idle_inputs();
        rsp0_ready = 1;
        n = 0;
        while (m_busy && n < 10) begin cycle(); n++; end

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            req0_valid = ($urandom_range(9, 0) < 6);
            req1_valid = ($urandom_range(9, 0) < 6);
            req0_op    = OPW'($urandom);
            req1_op    = OPW'($urandom);
            req0_a     = N'($urandom);
            req0_b     = N'($urandom_range(10, 0) == 0 ? $urandom : $urandom_range(9, 0));
            req1_a     = N'($urandom);
            req1_b     = N'($urandom_range(10, 0) == 0 ? $urandom : $urandom_range(9, 0));
            rsp0_ready = $urandom_range(1, 0);
            rsp1_ready = $urandom_range(1, 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
